// File: rtl/if_id_fetch_buffer.sv
// ---------------------------------------------------------------------------
// if_id_fetch_buffer
//
// IF/ID pipeline boundary register. Captures the IF PC and its branch
// prediction flag into the ID stage. It also presents the instruction word
// that the synchronous instruction RAM returns for that PC, which arrives
// one cycle after the address was issued.
//
// The RAM output has already moved on by the time IF is stalled. The stage
// therefore keeps a private copy of the ID instruction for the second and
// later cycles of a stall. Flushes and resets put a NOP bubble in the slot.
// Two saturating counters record stall and flush cycles for performance
// debugging.
//
// Ports
//   clk                     in   clock
//   rst_n                   in   asynchronous active-low reset
//   stall_id_i              in   hold ID contents at the end of this cycle
//   clear_id_i              in   flush ID to a bubble at end of cycle (beats stall)
//   pc_if_i                 in   PC currently in IF (RAM address this cycle)
//   branch_prediction_if_i  in   IF predicted taken for pc_if_i
//   instr_rdata_i           in   RAM data for the address of the previous cycle
//   pc_id_o                 out  PC of the instruction in ID
//   branch_prediction_id_o  out  prediction flag travelling with pc_id_o
//   instr_id_o              out  instruction in ID (NOP_INSTR when slot invalid)
//   valid_id_o              out  ID slot holds a real instruction
//   stall_cnt_o             out  saturating count of stall-without-clear cycles
//   flush_cnt_o             out  saturating count of clear cycles
// ---------------------------------------------------------------------------
module if_id_fetch_buffer #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 stall_id_i,
  input  logic                 clear_id_i,
  input  logic [31:0]          pc_if_i,
  input  logic                 branch_prediction_if_i,
  input  logic [31:0]          instr_rdata_i,
  output logic [31:0]          pc_id_o,
  output logic                 branch_prediction_id_o,
  output logic [31:0]          instr_id_o,
  output logic                 valid_id_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic        hold_active;
  logic [31:0] hold_reg;

  // During the first stall cycle, hold_active is still 0, so the live RAM
  // word is shown and captured. Later stall cycles, and the first cycle
  // after release, read the captured copy.
  always_comb begin
    instr_id_o = instr_rdata_i;
    if (!valid_id_o) begin
      instr_id_o = NOP_INSTR;
    end else if (hold_active) begin
      instr_id_o = hold_reg;
    end
  end

  // Pipeline state. Priority order is clear, then stall, then advance.
  // On a stall, the stage recaptures whatever it is currently showing. This
  // keeps the held word stable for a stall of any length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_id_o                <= 32'h0;
      branch_prediction_id_o <= 1'b0;
      valid_id_o             <= 1'b0;
      hold_active            <= 1'b0;
      hold_reg               <= NOP_INSTR;
    end else if (clear_id_i) begin
      pc_id_o                <= 32'h0;
      branch_prediction_id_o <= 1'b0;
      valid_id_o             <= 1'b0;
      hold_active            <= 1'b0;
    end else if (stall_id_i) begin
      hold_reg               <= instr_id_o;
      hold_active            <= 1'b1;
    end else begin
      pc_id_o                <= pc_if_i;
      branch_prediction_id_o <= branch_prediction_if_i;
      valid_id_o             <= 1'b1;
      hold_active            <= 1'b0;
    end
  end

  // Performance counters. They stick at all-ones instead of wrapping, and
  // only reset clears them. A stall that coincides with a clear counts as a
  // flush only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (clear_id_i) begin
      if (flush_cnt_o != CNT_MAX) begin
        flush_cnt_o <= flush_cnt_o + CNT_ONE;
      end
    end else if (stall_id_i) begin
      if (stall_cnt_o != CNT_MAX) begin
        stall_cnt_o <= stall_cnt_o + CNT_ONE;
      end
    end
  end

endmodule
